// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART TX arbiter, its byte requesters and the UART transmitter.
//   req          requester -> arbiter  per-requester "byte pending"
//   req_data     requester -> arbiter  byte of requester i at [8*i+7:8*i]
//   ack          arbiter -> requester  one-cycle accept pulse, one bit per requester
//   grant_id     arbiter -> requester  index of the current/last granted requester
//   busy         arbiter -> requester  arbiter not idle
//   timeout_err  arbiter -> requester  one-cycle pulse, UART never took the byte
//   data_ready   arbiter -> UART       data_in is valid
//   data_in      arbiter -> UART       byte to send
//   transmit_end UART -> arbiter       1 = transmitter idle
// The arbiter uses the master modport; clients and the UART sit on the slave side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [IdW-1:0]       grant_id;
  logic                 busy;
  logic                 timeout_err;
  logic                 data_ready;
  logic [7:0]           data_in;
  logic                 transmit_end;

  modport master (
    input  req, req_data, transmit_end,
    output ack, grant_id, busy, timeout_err, data_ready, data_in
  );

  modport slave (
    output req, req_data, transmit_end,
    input  ack, grant_id, busy, timeout_err, data_ready, data_in
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// A winning requester's byte is presented on data_in/data_ready until the UART
// drops transmit_end; the frame is then tracked until transmit_end rises again,
// followed by an optional GAP_CYCLES idle gap. Everything runs on uart_clk.
// Ports:
//   uart_clk  clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   bus       uart_tx_arbiter_if master side (requesters + UART TX handshake)
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 0
) (
  input  logic              uart_clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CntW = $clog2(START_TIMEOUT + 1);
  localparam int GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(START_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StLoad, StBusy, StGap} state_e;

  state_e          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;
  logic [GapW-1:0] gap_q;

  logic           found;
  logic [IdW-1:0] win;
  logic [IdW-1:0] scan_idx;
  logic [7:0]     win_byte;

  // Round-robin scan starting at ptr_q; the first pending requester wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IdW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IdW'(k)) win_byte = bus.req_data[8*k +: 8];
    end
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      ptr_q           <= '0;
      cnt_q           <= '0;
      gap_q           <= '0;
      bus.data_ready  <= 1'b0;
      bus.data_in     <= '0;
      bus.ack         <= '0;
      bus.grant_id    <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      bus.ack         <= '0;
      bus.timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Waiting for transmit_end also covers a frame left in flight by a reset.
          if (found && bus.transmit_end) begin
            bus.data_in    <= win_byte;
            bus.grant_id   <= win;
            bus.data_ready <= 1'b1;
            bus.busy       <= 1'b1;
            cnt_q          <= '0;
            state_q        <= StLoad;
          end
        end
        StLoad: begin
          if (!bus.transmit_end) begin
            bus.data_ready <= 1'b0;
            bus.ack        <= {{(NUM_REQ-1){1'b0}}, 1'b1} << bus.grant_id;
            ptr_q          <= (bus.grant_id == IdLast) ? '0 : bus.grant_id + 1'b1;
            state_q        <= StBusy;
          end else if (cnt_q == CntLast) begin
            // Abandon the byte; ptr_q is kept so the same requester is retried first.
            bus.data_ready  <= 1'b0;
            bus.timeout_err <= 1'b1;
            gap_q           <= '0;
            state_q         <= StGap;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBusy: begin
          if (bus.transmit_end) begin
            if (GAP_CYCLES == 0) begin
              bus.busy <= 1'b0;
              state_q  <= StIdle;
            end else begin
              gap_q   <= '0;
              state_q <= StGap;
            end
          end
        end
        StGap: begin
          // With no gap configured (timeout path) this state lasts one cycle.
          if (gap_q == GapLast) begin
            bus.busy <= 1'b0;
            state_q  <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int TO   = 64;
  localparam int GAP1 = 5;

  logic uart_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 uart_clk = ~uart_clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus0 ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus1 ();

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO), .GAP_CYCLES(0)) dut0 (
    .uart_clk(uart_clk),
    .rst_n   (rst_n),
    .bus     (bus0)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO), .GAP_CYCLES(GAP1)) dut1 (
    .uart_clk(uart_clk),
    .rst_n   (rst_n),
    .bus     (bus1)
  );

  int checks = 0;
  int errors = 0;

  // UART models: transmit_end falls 2 cycles after data_ready, frame 100 cycles.
  // stuck0 keeps the first UART from ever accepting (timeout scenario).
  bit stuck0 = 1'b0;
  int u0_wait = 0, u0_frame = 0, u1_wait = 0, u1_frame = 0;

  always @(posedge uart_clk) begin
    if (bus0.transmit_end) begin
      if (bus0.data_ready && !stuck0) begin
        if (u0_wait == 1) begin
          bus0.transmit_end <= 1'b0;
          u0_wait           <= 0;
          u0_frame          <= 100;
        end else u0_wait <= u0_wait + 1;
      end else u0_wait <= 0;
    end else if (u0_frame <= 1) bus0.transmit_end <= 1'b1;
    else u0_frame <= u0_frame - 1;
  end

  always @(posedge uart_clk) begin
    if (bus1.transmit_end) begin
      if (bus1.data_ready) begin
        if (u1_wait == 1) begin
          bus1.transmit_end <= 1'b0;
          u1_wait           <= 0;
          u1_frame          <= 100;
        end else u1_wait <= u1_wait + 1;
      end else u1_wait <= 0;
    end else if (u1_frame <= 1) bus1.transmit_end <= 1'b1;
    else u1_frame <= u1_frame - 1;
  end

  // Reference model: rotating priority pointer and the byte each requester holds.
  int         m_ptr = 0;
  logic [7:0] byte_m [N];

  function automatic int m_winner(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge uart_clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] b);
    bus0.req_data[8*i +: 8] = b;
    bus0.req[i]             = 1'b1;
    byte_m[i]               = b;
  endtask

  // One arbitration round on dut0: predicted winner, byte, ack pulse.
  // keep=1 leaves the requester asserted with the same byte (another frame pending).
  task automatic serve(input string tag, input bit keep, output int lat);
    int w;
    bit seen, acked;
    w    = m_winner(bus0.req, m_ptr);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 400) begin
      tick();
      lat++;
      seen = bus0.data_ready;
    end
    chk({tag, " grant"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, " id"}, 32'(bus0.grant_id), 32'(w));
    chk({tag, " data"}, 32'(bus0.data_in), 32'(byte_m[w]));
    chk({tag, " busy"}, 32'(bus0.busy), 32'd1);
    acked = 1'b0;
    for (int k = 0; k < 10 && !acked; k++) begin
      tick();
      acked = (bus0.ack != '0);
    end
    chk({tag, " ack"}, 32'(bus0.ack), 32'd1 << w);
    chk({tag, " dr_low"}, 32'(bus0.data_ready), 32'd0);
    m_ptr = (w + 1) % N;
    if (!keep) bus0.req[w] = 1'b0;
    tick();
    chk({tag, " ack_pulse"}, 32'(bus0.ack), 32'd0);
  endtask

  task automatic wait_te0();
    for (int k = 0; k < 300 && !bus0.transmit_end; k++) tick();
  endtask

  initial begin
    int lat, n, bl, hi;
    bit early, ackseen;
    bus0.req = '0; bus0.req_data = '0; bus0.transmit_end = 1'b1;
    bus1.req = '0; bus1.req_data = '0; bus1.transmit_end = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst data_ready", 32'(bus0.data_ready), 0);
    chk("rst data_in", 32'(bus0.data_in), 0);
    chk("rst ack", 32'(bus0.ack), 0);
    chk("rst grant_id", 32'(bus0.grant_id), 0);
    chk("rst busy", 32'(bus0.busy), 0);
    chk("rst timeout_err", 32'(bus0.timeout_err), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // T1 single request, one-cycle grant latency, busy held through the frame
    set_req(0, 8'hA5);
    serve("t1", 1'b0, lat);
    chk("t1 latency", 32'(lat), 1);
    bl = 0;
    for (int k = 0; k < 300; k++) begin
      if (!bus0.busy) bl++;
      if (bus0.transmit_end) break;
      tick();
    end
    chk("t1 busy_hold", 32'(bl), 0);
    tick();
    chk("t1 busy_end", 32'(bus0.busy), 0);

    // T2 all four requesters held
    set_req(0, 8'h11); set_req(1, 8'h22); set_req(2, 8'h33); set_req(3, 8'h44);
    for (int i = 0; i < 5; i++) serve("t2", 1'b1, lat);

    // T3 fairness between requesters 0 and 2
    bus0.req[1] = 1'b0; bus0.req[3] = 1'b0;
    for (int i = 0; i < 4; i++) serve("t3", 1'b1, lat);

    // Randomized request sets
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus0.req[i] && $urandom_range(1, 0) == 1) set_req(i, 8'($urandom));
      end
      if (bus0.req == '0) set_req(int'($urandom_range(N - 1, 0)), 8'($urandom));
      serve("rnd", 1'($urandom_range(1, 0)), lat);
    end

    // T4 timeout: drain, grant 0 so the pointer sits at 1, then UART never accepts
    bus0.req = '0;
    wait_te0();
    repeat (2) tick();
    set_req(0, 8'($urandom));
    serve("t4 pre", 1'b0, lat);
    stuck0 = 1'b1;
    set_req(1, 8'($urandom));
    n = 0;
    while (!bus0.data_ready && n < 400) begin
      tick();
      n++;
    end
    hi = 0;
    ackseen = 1'b0;
    while (bus0.data_ready && hi < 200) begin
      hi++;
      if (bus0.ack != '0) ackseen = 1'b1;
      tick();
    end
    chk("t4 dr_high", 32'(hi), 32'(TO));
    chk("t4 timeout_err", 32'(bus0.timeout_err), 1);
    chk("t4 no_ack", 32'(ackseen || bus0.ack != '0), 0);
    set_req(2, 8'($urandom));
    set_req(3, 8'($urandom));
    stuck0 = 1'b0;
    tick();
    chk("t4 terr_pulse", 32'(bus0.timeout_err), 0);
    serve("t4 regrant", 1'b0, lat);

    // T5 reset while a frame is in flight
    serve("t5 pre", 1'b0, lat);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t5 data_ready", 32'(bus0.data_ready), 0);
    chk("t5 data_in", 32'(bus0.data_in), 0);
    chk("t5 ack", 32'(bus0.ack), 0);
    chk("t5 grant_id", 32'(bus0.grant_id), 0);
    chk("t5 busy", 32'(bus0.busy), 0);
    chk("t5 timeout_err", 32'(bus0.timeout_err), 0);
    chk("t5 uart_busy", 32'(bus0.transmit_end), 0);
    set_req(1, 8'($urandom));
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    early = 1'b0;
    for (int k = 0; k < 300 && !bus0.transmit_end; k++) begin
      if (bus0.data_ready) early = 1'b1;
      tick();
    end
    chk("t5 no_early_grant", 32'(early), 0);
    serve("t5 post", 1'b0, lat);

    // Back-to-back with no gap: te seen, one cycle to leave BUSY, grant next edge
    wait_te0();
    n = 0;
    bl = 0;
    while (!bus0.data_ready && n < 50) begin
      if (!bus0.busy) bl++;
      n++;
      tick();
    end
    chk("gap0 spacing", 32'(n), 2);
    chk("gap0 idle", 32'(bl), 1);
    serve("gap0 next", 1'b0, lat);

    // T6 five-cycle gap on dut1
    bus1.req_data[7:0] = 8'h3C;
    bus1.req[0] = 1'b1;
    n = 0;
    while (!bus1.data_ready && n < 400) begin
      tick();
      n++;
    end
    chk("t6 first_id", 32'(bus1.grant_id), 0);
    chk("t6 first_data", 32'(bus1.data_in), 32'h3C);
    for (int k = 0; k < 10 && bus1.ack == '0; k++) tick();
    chk("t6 first_ack", 32'(bus1.ack), 1);
    bus1.req[0] = 1'b0;
    bus1.req_data[15:8] = 8'h5A;
    bus1.req[1] = 1'b1;
    for (int k = 0; k < 300 && !bus1.transmit_end; k++) tick();
    n = 0;
    bl = 0;
    while (!bus1.data_ready && n < 50) begin
      if (!bus1.busy) bl++;
      n++;
      tick();
    end
    chk("t6 spacing", 32'(n), 32'(2 + GAP1));
    chk("t6 idle", 32'(bl), 1);
    chk("t6 second_id", 32'(bus1.grant_id), 1);
    chk("t6 second_data", 32'(bus1.data_in), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
